// File: rtl/reg_file_param.sv
`default_nettype none
// reg_file_param: parametrised register file with write-through bypass, optional
// hardwired-zero r0, optional registered read ports and a one-per-cycle clear sweep.
module reg_file_param #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 2,
  parameter int ZERO_REG  = 1,
  parameter int READ_REG  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] rr1,
  input  logic [ADDR_BITS-1:0] rr2,
  output logic [WIDTH-1:0]     rd1,
  output logic [WIDTH-1:0]     rd2,
  input  logic [ADDR_BITS-1:0] wr,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 regwrite,
  input  logic                 clear,
  output logic                 busy,
  output logic                 wr_drop
);

  localparam int                   DEPTH    = 2**ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t               state_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 busy_q;
  logic                 wr_drop_q;
  logic [WIDTH-1:0]     regs_q [DEPTH];

  logic                 wr_zero;
  logic                 wr_ok;
  logic [WIDTH-1:0]     rd1_d;
  logic [WIDTH-1:0]     rd2_d;

  assign wr_zero = (ZERO_REG != 0) && (wr == '0);
  assign wr_ok   = regwrite && !busy_q && !wr_zero;

  // Zero-register override has the last word so it also masks the bypass.
  always_comb begin
    rd1_d = regs_q[rr1];
    rd2_d = regs_q[rr2];
    if (wr_ok && (rr1 == wr)) rd1_d = wd;
    if (wr_ok && (rr2 == wr)) rd2_d = wd;
    if ((ZERO_REG != 0) && (rr1 == '0)) rd1_d = '0;
    if ((ZERO_REG != 0) && (rr2 == '0)) rd2_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_drop_q <= regwrite && busy_q;
      case (state_q)
        IDLE: begin
          if (wr_ok) regs_q[wr] <= wd;
          if (clear) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          regs_q[idx_q] <= '0;
          idx_q         <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [WIDTH-1:0] rd1_q;
      logic [WIDTH-1:0] rd2_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rd1_q <= '0;
          rd2_q <= '0;
        end else begin
          rd1_q <= rd1_d;
          rd2_q <= rd2_d;
        end
      end
      assign rd1 = rd1_q;
      assign rd2 = rd2_q;
    end else begin : g_rd_comb
      assign rd1 = rd1_d;
      assign rd2 = rd2_d;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// tb_reg_file_param: directed checks of three register-file configurations
// against expected values queued as each stimulus step is applied.
module tb_reg_file_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // A: defaults (16-bit, 4 regs, zero r0, combinational reads)
  logic        a_reset, a_regwrite, a_clear, a_busy, a_wr_drop;
  logic [1:0]  a_rr1, a_rr2, a_wr;
  logic [15:0] a_wd, a_rd1, a_rd2;
  // B: registered reads
  logic        b_reset, b_regwrite, b_clear, b_busy, b_wr_drop;
  logic [1:0]  b_rr1, b_rr2, b_wr;
  logic [15:0] b_wd, b_rd1, b_rd2;
  // C: 32-bit, 8 regs, r0 ordinary
  logic        c_reset, c_regwrite, c_clear, c_busy, c_wr_drop;
  logic [2:0]  c_rr1, c_rr2, c_wr;
  logic [31:0] c_wd, c_rd1, c_rd2;

  reg_file_param u_a (
    .clock(clock), .reset(a_reset), .rr1(a_rr1), .rr2(a_rr2), .rd1(a_rd1), .rd2(a_rd2),
    .wr(a_wr), .wd(a_wd), .regwrite(a_regwrite), .clear(a_clear), .busy(a_busy), .wr_drop(a_wr_drop)
  );

  reg_file_param #(.WIDTH(16), .ADDR_BITS(2), .ZERO_REG(1), .READ_REG(1)) u_b (
    .clock(clock), .reset(b_reset), .rr1(b_rr1), .rr2(b_rr2), .rd1(b_rd1), .rd2(b_rd2),
    .wr(b_wr), .wd(b_wd), .regwrite(b_regwrite), .clear(b_clear), .busy(b_busy), .wr_drop(b_wr_drop)
  );

  reg_file_param #(.WIDTH(32), .ADDR_BITS(3), .ZERO_REG(0), .READ_REG(0)) u_c (
    .clock(clock), .reset(c_reset), .rr1(c_rr1), .rr2(c_rr2), .rd1(c_rd1), .rd2(c_rd2),
    .wr(c_wr), .wd(c_wd), .regwrite(c_regwrite), .clear(c_clear), .busy(c_busy), .wr_drop(c_wr_drop)
  );

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_write(input logic [1:0] a, input logic [15:0] d);
    a_regwrite = 1'b1; a_wr = a; a_wd = d;
    tick();
    a_regwrite = 1'b0;
  endtask

  task automatic c_write(input logic [2:0] a, input logic [31:0] d);
    c_regwrite = 1'b1; c_wr = a; c_wd = d;
    tick();
    c_regwrite = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_regwrite = 1'b0; a_clear = 1'b0; a_rr1 = '0; a_rr2 = '0; a_wr = '0; a_wd = '0;
    b_reset = 1'b1; b_regwrite = 1'b0; b_clear = 1'b0; b_rr1 = '0; b_rr2 = '0; b_wr = '0; b_wd = '0;
    c_reset = 1'b1; c_regwrite = 1'b0; c_clear = 1'b0; c_rr1 = '0; c_rr2 = '0; c_wr = '0; c_wd = '0;
    tick();
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;

    // ---- A: reset state
    a_rr1 = 2'd1; a_rr2 = 2'd3;
    expect_val("a_rst_rd1", 32'h0); expect_val("a_rst_rd2", 32'h0);
    expect_val("a_rst_busy", 32'h0); expect_val("a_rst_wr_drop", 32'h0);
    #1;
    check(32'(a_rd1)); check(32'(a_rd2)); check(32'(a_busy)); check(32'(a_wr_drop));

    // ---- A: basic writes, r0 write discarded
    a_write(2'd1, 16'hA5A5);
    a_write(2'd2, 16'h1234);
    a_write(2'd3, 16'hFFFF);
    a_write(2'd0, 16'h7777);
    a_rr1 = 2'd1; a_rr2 = 2'd3;
    expect_val("a_rd_r1", 32'hA5A5); expect_val("a_rd_r3", 32'hFFFF);
    #1;
    check(32'(a_rd1)); check(32'(a_rd2));
    a_rr1 = 2'd0; a_rr2 = 2'd2;
    expect_val("a_rd_r0", 32'h0); expect_val("a_rd_r2", 32'h1234); expect_val("a_r0_no_drop", 32'h0);
    #1;
    check(32'(a_rd1)); check(32'(a_rd2)); check(32'(a_wr_drop));

    // ---- A: same-cycle bypass, then without regwrite
    a_rr1 = 2'd2; a_regwrite = 1'b1; a_wr = 2'd2; a_wd = 16'hBEEF;
    expect_val("a_bypass", 32'hBEEF);
    #1;
    check(32'(a_rd1));
    a_regwrite = 1'b0;
    expect_val("a_no_bypass", 32'h1234);
    #1;
    check(32'(a_rd1));
    a_rr2 = 2'd0; a_regwrite = 1'b1; a_wr = 2'd0; a_wd = 16'h9999;
    expect_val("a_zero_bypass", 32'h0);
    #1;
    check(32'(a_rd2));
    a_regwrite = 1'b0;

    // ---- A: clear sweep with a dropped write
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    a_regwrite = 1'b1; a_wr = 2'd2; a_wd = 16'h5555; a_rr1 = 2'd2;
    expect_val("a_busy_c1", 32'h1); expect_val("a_sweep_no_bypass", 32'h1234);
    #1;
    check(32'(a_busy)); check(32'(a_rd1));
    tick();
    a_regwrite = 1'b0;
    expect_val("a_wr_drop_pulse", 32'h1); expect_val("a_busy_c2", 32'h1);
    check(32'(a_wr_drop)); check(32'(a_busy));
    tick();
    a_rr1 = 2'd1;
    expect_val("a_wr_drop_end", 32'h0); expect_val("a_busy_c3", 32'h1); expect_val("a_sweep_r1", 32'h0);
    #1;
    check(32'(a_wr_drop)); check(32'(a_busy)); check(32'(a_rd1));
    tick();
    expect_val("a_busy_c4", 32'h1);
    check(32'(a_busy));
    tick();
    a_rr1 = 2'd1; a_rr2 = 2'd2;
    expect_val("a_busy_done", 32'h0); expect_val("a_clr_r1", 32'h0); expect_val("a_clr_r2", 32'h0);
    #1;
    check(32'(a_busy)); check(32'(a_rd1)); check(32'(a_rd2));
    a_rr1 = 2'd3;
    expect_val("a_clr_r3", 32'h0);
    #1;
    check(32'(a_rd1));

    // ---- A: clear + write on the same edge; clear held into the sweep is ignored
    a_clear = 1'b1; a_regwrite = 1'b1; a_wr = 2'd3; a_wd = 16'h1111;
    tick();
    a_regwrite = 1'b0; a_rr1 = 2'd3;
    expect_val("a_cw_landed", 32'h1111); expect_val("a_cw_busy", 32'h1);
    #1;
    check(32'(a_rd1)); check(32'(a_busy));
    tick();
    a_clear = 1'b0;
    tick();
    tick();
    expect_val("a_cw_busy_c4", 32'h1);
    check(32'(a_busy));
    tick();
    expect_val("a_cw_busy_done", 32'h0); expect_val("a_cw_r3_cleared", 32'h0);
    #1;
    check(32'(a_busy)); check(32'(a_rd1));

    // ---- B: registered read latency with bypass capture
    b_regwrite = 1'b1; b_wr = 2'd3; b_wd = 16'h0F0F; b_rr2 = 2'd3; b_rr1 = 2'd1;
    expect_val("b_rd2_pre_edge", 32'h0);
    #1;
    check(32'(b_rd2));
    tick();
    b_regwrite = 1'b0; b_rr1 = 2'd3;
    expect_val("b_rd2_post_edge", 32'h0F0F); expect_val("b_rd1_pre", 32'h0);
    #1;
    check(32'(b_rd2)); check(32'(b_rd1));
    tick();
    expect_val("b_rd1_post", 32'h0F0F); expect_val("b_busy", 32'h0); expect_val("b_wr_drop", 32'h0);
    check(32'(b_rd1)); check(32'(b_busy)); check(32'(b_wr_drop));

    // ---- C: wide config, ordinary r0, reset mid-sweep
    c_write(3'd0, 32'hDEADBEEF);
    c_write(3'd7, 32'h00000001);
    c_write(3'd3, 32'h00000033);
    c_rr1 = 3'd0; c_rr2 = 3'd7;
    expect_val("c_rd_r0", 32'hDEADBEEF); expect_val("c_rd_r7", 32'h1);
    #1;
    check(c_rd1); check(c_rd2);
    c_clear = 1'b1;
    tick();
    c_clear = 1'b0;
    expect_val("c_busy", 32'h1);
    check(32'(c_busy));
    tick();
    tick();
    #2;
    c_reset = 1'b1;
    expect_val("c_rst_busy", 32'h0); expect_val("c_rst_r0", 32'h0); expect_val("c_rst_r7", 32'h0);
    #1;
    check(32'(c_busy)); check(c_rd1); check(c_rd2);
    c_rr1 = 3'd3;
    expect_val("c_rst_r3", 32'h0);
    #1;
    check(c_rd1);
    c_reset = 1'b0;
    tick();
    expect_val("c_aborted_busy", 32'h0); expect_val("c_wr_drop", 32'h0);
    check(32'(c_busy)); check(32'(c_wr_drop));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised MIPS register file and the successor to the fixed 4-register, 16-bit file. It is configurable in data width and register count. It has two combinational or registered read ports, one write port with write-through bypass, and an optional hardwired-zero register 0. A clear sequencer zeroes the array one register per cycle on request, so the datapath can flush state without a global reset.

Parameters:
WIDTH, 16, data width of each register and of wd/rd1/rd2
ADDR_BITS, 2, register address width; DEPTH = 2**ADDR_BITS registers
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary storage
READ_REG, 0, 0 = combinational read ports; 1 = read ports registered (1-cycle latency)

Ports:
clock     input   1          single system clock, all state updates on rising edge
reset     input   1          asynchronous, active-high; clears all state immediately
rr1       input   ADDR_BITS  read address, port 1
rr2       input   ADDR_BITS  read address, port 2
rd1       output  WIDTH      read data, port 1
rd2       output  WIDTH      read data, port 2
wr        input   ADDR_BITS  write address
wd        input   WIDTH      write data
regwrite  input   1          write enable, sampled on rising clock
clear     input   1          start clear sweep, sampled on rising clock
busy      output  1          high while clear sweep in progress
wr_drop   output  1          one-cycle pulse: a write was rejected because busy=1

Behaviour:
- Clock and reset are fixed: one clock (clock); reset is asynchronous and active-high (reset).
- Reset: all registers = 0; FSM = IDLE; sweep index = 0; busy = 0; wr_drop = 0; registered rd1/rd2 = 0 (READ_REG=1). Reset asserted mid-sweep aborts the sweep and returns to IDLE.
- Write (IDLE only): at a rising edge with regwrite=1, reg[wr] <= wd. If ZERO_REG=1 and wr=0, the write is discarded silently. wr_drop is not asserted in that case.
- Write during busy: the write is discarded, and wr_drop = 1 for the following cycle. wr_drop is otherwise 0.
- Read, READ_REG=0: rd1 = reg[rr1] combinationally, and likewise rd2.
- Bypass: when regwrite=1, busy=0, rr1=wr, and the write is not discarded, rd1 = wd in the same cycle. The same rule applies to rd2.
- Read, READ_REG=1: rd1/rd2 are captured at each rising edge using the same bypass-inclusive value. They therefore show the post-write contents one cycle after the address is presented.
- Zero register: with ZERO_REG=1, rr=0 always returns 0, including under bypass.
- FSM, two states:
  - IDLE: clear=1 at an edge moves to SWEEP with index=0 and busy=1. A regwrite sampled at the same edge is still performed, and the sweep later clears it.
  - SWEEP: each edge writes reg[index] <= 0 and increments index. At the edge that clears index DEPTH-1, the FSM moves to IDLE and busy drops.
  - busy is high for exactly DEPTH cycles.
  - clear while in SWEEP is ignored; the sweep is not restarted.
- Reads during SWEEP return the current array contents, where indices below the sweep index are already 0. Bypass is disabled during SWEEP.
- Index wrap: the index is ADDR_BITS wide, and the terminal state is detected at index = DEPTH-1. No overflow is visible.
- Width: wd and the storage are exactly WIDTH bits, with no sign or zero extension. Out-of-range addresses cannot occur because addresses are full ADDR_BITS.

Test Plan:
- Defaults, write 16'hA5A5 to r1, 16'h1234 to r2, 16'hFFFF to r3, 16'h7777 to r0 -> rr1=1/rr2=3 read A5A5/FFFF; rr=0 reads 0000; r2 reads 1234.
- Defaults, regwrite=1, wr=2, wd=16'hBEEF, rr1=2, before the edge -> rd1=BEEF combinationally (bypass); with regwrite=0 the same rr1 returns the old r2 value.
- READ_REG=1, write 16'h0F0F to r3 and present rr2=3 the same cycle -> rd2=0F0F one cycle after the edge, not earlier.
- Defaults, fill r1..r3 nonzero, pulse clear -> busy=1 for exactly 4 cycles; r1..r3 read 0 afterwards; a regwrite to r2=16'h5555 during busy is dropped with a 1-cycle wr_drop pulse, and r2 still reads 0.
- clear and regwrite(wr=3, wd=16'h1111) on the same edge -> write lands, busy rises, and r3 reads 0 after the sweep completes.
- ADDR_BITS=3, WIDTH=32, ZERO_REG=0: write r0=32'hDEADBEEF and r7=32'h1 -> both read back; assert reset mid-sweep -> all registers read 0 immediately and busy=0.
